// File: rtl/regfile_access_master_if.sv
// Command, response and register-file signal bundle for regfile_access_master.
// valid/ready: a transfer happens on a rising clk edge where valid and ready are both high; the producer holds its payload stable while valid is high and not yet accepted.
interface regfile_access_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] rf_read_reg;
  logic [DATA_W-1:0] rf_read_data;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_write_en;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, rf_read_data,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output rf_read_reg, rf_write_reg, rf_write_data, rf_write_en, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, rf_read_data,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  rf_read_reg, rf_write_reg, rf_write_data, rf_write_en, busy
  );
endinterface

// File: rtl/regfile_access_master.sv
// Register-file initiator: one outstanding read/write command, valid/ready response.
// Optional write read-back check enabled by defining REGFILE_READBACK_VERIFY_EN.
module regfile_access_master #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int RD_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_access_master_if.master io_bus,
  output logic [2:0]              o_dbg_state
);
  localparam int                CNT_W      = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0]  LAT_INIT   = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
`ifdef REGFILE_READBACK_VERIFY_EN
    S_VERIFY = 3'd4,
`endif
    S_RESP   = 3'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic [ADDR_W-1:0] r_rd_reg;
  logic [ADDR_W-1:0] r_wr_reg;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_accept;
  logic              w_illegal;
  logic              w_lat_done;

  assign w_accept   = io_bus.cmd_valid && (r_state == S_IDLE);
  // Address 0 is hard-wired to zero in the register file, so writing it is an error.
  assign w_illegal  = (io_bus.cmd_addr >= NUM_REGS_A) ||
                      (io_bus.cmd_write && (io_bus.cmd_addr == '0));
  assign w_lat_done = (r_lat_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next               = r_state;
    io_bus.cmd_ready     = 1'b0;
    io_bus.rsp_valid     = 1'b0;
    io_bus.rf_write_en   = 1'b0;
    io_bus.busy          = 1'b1;
    case (r_state)
      S_IDLE: begin
        io_bus.cmd_ready = 1'b1;
        io_bus.busy      = 1'b0;
        if (w_accept) begin
          if (w_illegal)             w_next = S_RESP;
          else if (io_bus.cmd_write) w_next = S_WRITE;
          else                       w_next = S_READ;
        end
      end
      S_WRITE: begin
        io_bus.rf_write_en = 1'b1;
`ifdef REGFILE_READBACK_VERIFY_EN
        w_next = S_VERIFY;
`else
        w_next = S_RESP;
`endif
      end
      S_READ: begin
        if (w_lat_done) w_next = S_RESP;
      end
`ifdef REGFILE_READBACK_VERIFY_EN
      S_VERIFY: begin
        if (w_lat_done) w_next = S_RESP;
      end
`endif
      S_RESP: begin
        io_bus.rsp_valid = 1'b1;
        if (io_bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // rf_* address/data registers load only when a legal access needs them, so they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_cnt   <= '0;
      r_rd_reg    <= '0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_illegal;
            if (!w_illegal) begin
              if (io_bus.cmd_write) begin
                r_wr_reg  <= io_bus.cmd_addr;
                r_wr_data <= io_bus.cmd_wdata;
              end else begin
                r_rd_reg  <= io_bus.cmd_addr;
                r_lat_cnt <= LAT_INIT;
              end
            end
          end
        end
`ifdef REGFILE_READBACK_VERIFY_EN
        S_WRITE: begin
          r_rd_reg  <= r_wr_reg;
          r_lat_cnt <= LAT_INIT;
        end
        S_VERIFY: begin
          if (!w_lat_done) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end else begin
            r_rsp_rdata <= io_bus.rf_read_data;
            r_rsp_err   <= (io_bus.rf_read_data != r_wr_data);
          end
        end
`endif
        S_READ: begin
          if (!w_lat_done) r_lat_cnt   <= r_lat_cnt - 1'b1;
          else             r_rsp_rdata <= io_bus.rf_read_data;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.rsp_rdata     = r_rsp_rdata;
  assign io_bus.rsp_err       = r_rsp_err;
  assign io_bus.rf_read_reg   = r_rd_reg;
  assign io_bus.rf_write_reg  = r_wr_reg;
  assign io_bus.rf_write_data = r_wr_data;
  assign o_dbg_state          = r_state;
endmodule
